// File: rtl/onehot_sequencer_if.sv
// Request/strobe bundle between a command source and the one-hot sequencer.
interface onehot_sequencer_if #(
  parameter int SEL_W  = 3,
  parameter int HOLD_W = 4
);
  localparam int OUT_W = 2 ** SEL_W;

  logic              enable;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic [HOLD_W-1:0] in_hold;
  logic              in_scan;
  logic [OUT_W-1:0]  out;
  logic              busy;
  logic              done;

  modport master (
    output enable, in_valid, in_sel, in_hold, in_scan,
    input  in_ready, out, busy, done
  );

  modport slave (
    input  enable, in_valid, in_sel, in_hold, in_scan,
    output in_ready, out, busy, done
  );
endinterface

// File: rtl/onehot_sequencer.sv
// Registered SEL_W-to-2^SEL_W one-hot strobe driver with per-code dwell and
// an optional scan that walks the strobe through every output once.
module onehot_sequencer #(
  parameter int SEL_W  = 3,
  parameter int HOLD_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  onehot_sequencer_if.slave bus
);
  localparam int OUT_W = 2 ** SEL_W;
  localparam logic [SEL_W:0] LAST_CODE = (SEL_W+1)'(OUT_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state, state_nx;
  logic [SEL_W-1:0]  code, code_nx;
  logic [HOLD_W-1:0] hold, hold_nx;
  logic [HOLD_W-1:0] cnt, cnt_nx;
  logic              scan, scan_nx;
  logic [SEL_W:0]    ncode, ncode_nx;
  logic [OUT_W-1:0]  out_r, out_nx;
  logic              busy_r, busy_nx;
  logic              done_r, done_nx;
  logic              ready;
  logic              accept;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] c);
    logic [OUT_W-1:0] o;
    o    = '0;
    o[c] = 1'b1;
    return o;
  endfunction

  assign ready        = rst_n & bus.enable & (state == IDLE);
  assign accept       = bus.in_valid & ready;
  assign bus.in_ready = ready;
  assign bus.out      = out_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      code   <= '0;
      hold   <= '0;
      cnt    <= '0;
      scan   <= 1'b0;
      ncode  <= '0;
      out_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nx;
      code   <= code_nx;
      hold   <= hold_nx;
      cnt    <= cnt_nx;
      scan   <= scan_nx;
      ncode  <= ncode_nx;
      out_r  <= out_nx;
      busy_r <= busy_nx;
      done_r <= done_nx;
    end
  end

  // busy_r low in ACTIVE marks the cycle between accept and the first driven code
  always_comb begin
    state_nx = state;
    code_nx  = code;
    hold_nx  = hold;
    cnt_nx   = cnt;
    scan_nx  = scan;
    ncode_nx = ncode;
    out_nx   = out_r;
    busy_nx  = busy_r;
    done_nx  = 1'b0;
    if (!bus.enable) begin
      state_nx = IDLE;
      code_nx  = '0;
      hold_nx  = '0;
      cnt_nx   = '0;
      scan_nx  = 1'b0;
      ncode_nx = '0;
      out_nx   = '0;
      busy_nx  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          out_nx  = '0;
          busy_nx = 1'b0;
          if (accept) begin
            code_nx  = bus.in_sel;
            hold_nx  = bus.in_hold;
            scan_nx  = bus.in_scan;
            cnt_nx   = '0;
            ncode_nx = '0;
            state_nx = ACTIVE;
          end
        end
        ACTIVE: begin
          if (!busy_r) begin
            out_nx  = onehot(code);
            busy_nx = 1'b1;
          end else if (cnt != hold) begin
            cnt_nx = cnt + HOLD_W'(1);
          end else if (!scan || ncode == LAST_CODE) begin
            state_nx = IDLE;
            out_nx   = '0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end else begin
            code_nx  = code + SEL_W'(1);
            cnt_nx   = '0;
            ncode_nx = ncode + (SEL_W+1)'(1);
            out_nx   = onehot(code + SEL_W'(1));
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end
endmodule
